// File: rtl/alu_trojan_pkg.sv
// Shared types and the width-generic ALU datapath function for alu_trojan_param.
package alu_trojan_pkg;

   localparam int unsigned MAX_W = 64;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_SLT = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMING = 2'd1,
      ACTIVE = 2'd2
   } trig_state_e;

   // Operands arrive zero-extended to MAX_W; w is the live width. Returns {carry, overflow, result_raw}.
   function automatic logic [MAX_W+1:0] alu_compute(input logic [MAX_W-1:0] a,
                                                    input logic [MAX_W-1:0] b,
                                                    input alu_op_e          op,
                                                    input int unsigned      w);
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] res;
      logic [MAX_W-1:0] sa;
      logic [MAX_W-1:0] sb;
      logic [MAX_W:0]   sum;
      logic [5:0]       msb;
      int unsigned      sh;
      logic             c;
      logic             v;
      mask = (MAX_W'(1) << w) - MAX_W'(1);
      msb  = 6'(w - 1);
      sh   = 32'(b[5:0]) & (w - 1);
      sa   = a[msb] ? (a | ~mask) : a;
      sb   = b[msb] ? (b | ~mask) : b;
      sum  = '0;
      res  = '0;
      c    = 1'b0;
      v    = 1'b0;
      case (op)
         OP_ADD: begin
            sum = {1'b0, a} + {1'b0, b};
            res = sum[MAX_W-1:0] & mask;
            c   = sum[7'(w)];
            v   = (a[msb] == b[msb]) && (res[msb] != a[msb]);
         end
         OP_SUB: begin
            res = (a - b) & mask;
            c   = (a < b);
            v   = (a[msb] != b[msb]) && (res[msb] != a[msb]);
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_SHL: begin
            res = (a << sh) & mask;
            c   = (sh != 0) ? a[6'(w - sh)] : 1'b0;
         end
         OP_SHR: begin
            res = a >> sh;
            c   = (sh != 0) ? a[6'(sh - 1)] : 1'b0;
         end
         OP_SLT: res = MAX_W'($signed(sa) < $signed(sb));
         default: res = '0;
      endcase
      return {c, v, res};
   endfunction

endpackage

// File: rtl/alu_trojan_param_if.sv
// Transaction and result bus between the stimulus side and the ALU.
interface alu_trojan_param_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       op;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             negative;
   logic             overflow;
   logic             trojan_active;

   modport master (
      output in_valid, A, B, op,
      input  out_valid, result, carry, zero, negative, overflow, trojan_active
   );

   modport slave (
      input  in_valid, A, B, op,
      output out_valid, result, carry, zero, negative, overflow, trojan_active
   );
endinterface

// File: rtl/trojan_trigger_fsm.sv
// Trigger FSM: counts consecutive matching transactions; idle cycles hold state and count.
module trojan_trigger_fsm
   import alu_trojan_pkg::*;
#(
   parameter int unsigned      WIDTH      = 8,
   parameter logic [WIDTH-1:0] TRIG_A     = '1,
   parameter logic [WIDTH-1:0] TRIG_B     = '1,
   parameter logic [2:0]       TRIG_OP    = 3'b000,
   parameter int unsigned      TRIG_COUNT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [2:0]       i_op,
   output logic             o_active,
   output logic             o_match_c
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TRIG_COUNT);

   trig_state_e      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_active;

   assign o_match_c = i_valid && (i_a == TRIG_A) && (i_b == TRIG_B) && (i_op == TRIG_OP);
   assign o_active  = r_active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_active <= 1'b0;
      end else if (i_valid) begin
         if (!o_match_c) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_active <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_cnt <= CNT_W'(1);
                  if (CNT_MAX == CNT_W'(1)) begin
                     r_state  <= ACTIVE;
                     r_active <= 1'b1;
                  end else begin
                     r_state <= ARMING;
                  end
               end
               ARMING: begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt + CNT_W'(1) == CNT_MAX) begin
                     r_state  <= ACTIVE;
                     r_active <= 1'b1;
                  end
               end
               ACTIVE: begin
                  r_cnt    <= CNT_MAX;
                  r_active <= 1'b1;
               end
               default: begin
                  r_state  <= IDLE;
                  r_cnt    <= '0;
                  r_active <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/alu_trojan_param.sv
// Single-cycle pipelined ALU with optional trigger FSM and XOR payload on the registered result.
module alu_trojan_param
   import alu_trojan_pkg::*;
#(
   parameter int unsigned      WIDTH        = 8,
   parameter bit               TROJAN_EN    = 1'b1,
   parameter logic [WIDTH-1:0] TRIG_A       = '1,
   parameter logic [WIDTH-1:0] TRIG_B       = '1,
   parameter logic [2:0]       TRIG_OP      = 3'b000,
   parameter int unsigned      TRIG_COUNT   = 3,
   parameter logic [WIDTH-1:0] PAYLOAD_MASK = WIDTH'(1)
) (
   input  logic              clk,
   input  logic              rst,
   alu_trojan_param_if.slave bus
);

   logic [MAX_W+1:0] w_alu;
   logic [WIDTH-1:0] w_raw;
   logic [WIDTH-1:0] w_res;
   logic             w_active;
   logic             w_match;
   logic             w_corrupt;
   logic             w_unused_hi;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic             r_zero;
   logic             r_negative;
   logic             r_overflow;

   assign w_alu = alu_compute(MAX_W'(bus.A), MAX_W'(bus.B), alu_op_e'(bus.op), WIDTH);
   assign w_raw = w_alu[WIDTH-1:0];

   if (WIDTH < MAX_W) begin : g_hi
      assign w_unused_hi = ^w_alu[MAX_W-1:WIDTH];
   end else begin : g_nohi
      assign w_unused_hi = 1'b0;
   end

   if (TROJAN_EN) begin : g_trojan
      trojan_trigger_fsm #(
         .WIDTH      (WIDTH),
         .TRIG_A     (TRIG_A),
         .TRIG_B     (TRIG_B),
         .TRIG_OP    (TRIG_OP),
         .TRIG_COUNT (TRIG_COUNT)
      ) u_trig (
         .clk       (clk),
         .rst       (rst),
         .i_valid   (bus.in_valid),
         .i_a       (bus.A),
         .i_b       (bus.B),
         .i_op      (bus.op),
         .o_active  (w_active),
         .o_match_c (w_match)
      );
   end else begin : g_clean
      assign w_active = 1'b0;
      assign w_match  = 1'b0;
   end

   // Payload uses the FSM state as it stood when this transaction is accepted.
   assign w_corrupt = w_active && w_match;
   assign w_res     = w_corrupt ? (w_raw ^ PAYLOAD_MASK) : w_raw;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_carry     <= 1'b0;
         r_zero      <= 1'b0;
         r_negative  <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_result   <= w_res;
            r_carry    <= w_alu[MAX_W+1];
            r_overflow <= w_alu[MAX_W];
            r_zero     <= (w_res == '0);
            r_negative <= w_res[WIDTH-1];
         end
      end
   end

   assign bus.out_valid     = r_out_valid;
   assign bus.result        = r_result;
   assign bus.carry         = r_carry;
   assign bus.zero          = r_zero;
   assign bus.negative      = r_negative;
   assign bus.overflow      = r_overflow;
   assign bus.trojan_active = w_active;

endmodule

// File: tb/tb_alu_trojan_param.sv
// Scoreboard bench for alu_trojan_param: an infected instance and a clean (TROJAN_EN=0) instance.
module tb_alu_trojan_param;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   alu_trojan_param_if #(.WIDTH(8)) bus1 ();
   alu_trojan_param_if #(.WIDTH(8)) bus0 ();

   alu_trojan_param #(
      .WIDTH(8), .TROJAN_EN(1'b1), .TRIG_A(8'hFF), .TRIG_B(8'hFF),
      .TRIG_OP(3'b000), .TRIG_COUNT(3), .PAYLOAD_MASK(8'h01)
   ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   alu_trojan_param #(
      .WIDTH(8), .TROJAN_EN(1'b0), .TRIG_A(8'hFF), .TRIG_B(8'hFF),
      .TRIG_OP(3'b000), .TRIG_COUNT(3), .PAYLOAD_MASK(8'h01)
   ) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

   typedef struct packed {
      logic [7:0] result;
      logic       carry;
      logic       zero;
      logic       negative;
      logic       overflow;
   } exp_t;

   exp_t q1[$];
   exp_t q0[$];

   function automatic exp_t mk(input logic [7:0] r, input logic c, input logic v);
      exp_t e;
      e.result   = r;
      e.carry    = c;
      e.zero     = (r == 8'h00);
      e.negative = r[7];
      e.overflow = v;
      return e;
   endfunction

   // Scoreboard pop/compare for each DUT
   always @(negedge clk) begin
      if (bus1.out_valid === 1'b1) begin
         exp_t got;
         exp_t exp;
         got = '{bus1.result, bus1.carry, bus1.zero, bus1.negative, bus1.overflow};
         total++;
         if (q1.size() == 0) begin
            bad++;
            $display("FAIL dut1_unexpected_output got=%h required=none", got);
         end else begin
            exp = q1.pop_front();
            if (got !== exp) begin
               bad++;
               $display("FAIL dut1_result got={res=%h c=%b z=%b n=%b v=%b} required={res=%h c=%b z=%b n=%b v=%b}",
                        got.result, got.carry, got.zero, got.negative, got.overflow,
                        exp.result, exp.carry, exp.zero, exp.negative, exp.overflow);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (bus0.out_valid === 1'b1) begin
         exp_t got;
         exp_t exp;
         got = '{bus0.result, bus0.carry, bus0.zero, bus0.negative, bus0.overflow};
         total++;
         if (q0.size() == 0) begin
            bad++;
            $display("FAIL dut0_unexpected_output got=%h required=none", got);
         end else begin
            exp = q0.pop_front();
            if (got !== exp) begin
               bad++;
               $display("FAIL dut0_result got={res=%h c=%b z=%b n=%b v=%b} required={res=%h c=%b z=%b n=%b v=%b}",
                        got.result, got.carry, got.zero, got.negative, got.overflow,
                        exp.result, exp.carry, exp.zero, exp.negative, exp.overflow);
            end
         end
      end
   end

   task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [7:0] er, input logic ec, input logic ev);
      @(negedge clk);
      bus1.in_valid = 1'b1;
      bus1.A        = a;
      bus1.B        = b;
      bus1.op       = op;
      q1.push_back(mk(er, ec, ev));
   endtask

   task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [7:0] er, input logic ec, input logic ev);
      @(negedge clk);
      bus0.in_valid = 1'b1;
      bus0.A        = a;
      bus0.B        = b;
      bus0.op       = op;
      q0.push_back(mk(er, ec, ev));
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus1.in_valid = 1'b0;
      bus0.in_valid = 1'b0;
      for (int i = 1; i < n; i++) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus1.in_valid = 1'b0;
      bus0.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Bounded wait for outstanding results, then require the queues to be empty
   task automatic drain(input string name);
      idle(3);
      total++;
      if (q1.size() != 0 || q0.size() != 0) begin
         bad++;
         $display("FAIL %s_drain pending dut1=%0d dut0=%0d required=0", name, q1.size(), q0.size());
         q1.delete();
         q0.delete();
      end
   endtask

   task automatic test_reset();
      logic [13:0] got;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      got = {bus1.out_valid, bus1.result, bus1.carry, bus1.zero, bus1.negative,
             bus1.overflow, bus1.trojan_active};
      total++;
      if (got !== 14'h0) begin
         bad++;
         $display("FAIL reset_state got=%h required=0000", got);
      end
      rst = 1'b0;
   endtask

   task automatic test_arith();
      send1(8'h7F, 8'h01, 3'b000, 8'h80, 1'b0, 1'b1);
      send1(8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b0);
      send1(8'h00, 8'h01, 3'b001, 8'hFF, 1'b1, 1'b0);
      send1(8'h80, 8'h01, 3'b001, 8'h7F, 1'b0, 1'b1);
      send1(8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0, 1'b0);
      send1(8'hF0, 8'h0F, 3'b011, 8'hFF, 1'b0, 1'b0);
      send1(8'hAA, 8'hFF, 3'b100, 8'h55, 1'b0, 1'b0);
      send1(8'h81, 8'h01, 3'b101, 8'h02, 1'b1, 1'b0);
      send1(8'h81, 8'h08, 3'b101, 8'h81, 1'b0, 1'b0);
      send1(8'h81, 8'h01, 3'b110, 8'h40, 1'b1, 1'b0);
      send1(8'h0C, 8'h03, 3'b110, 8'h01, 1'b1, 1'b0);
      send1(8'hFE, 8'h01, 3'b111, 8'h01, 1'b0, 1'b0);
      send1(8'h01, 8'hFE, 3'b111, 8'h00, 1'b0, 1'b0);
      drain("arith");
   endtask

   task automatic test_arming();
      do_reset();
      send1(8'hFF, 8'hFF, 3'b000, 8'hFE, 1'b1, 1'b0);
      send1(8'hFF, 8'hFF, 3'b000, 8'hFE, 1'b1, 1'b0);
      send1(8'hFF, 8'hFF, 3'b000, 8'hFE, 1'b1, 1'b0);
      total++;
      if (bus1.trojan_active !== 1'b0) begin
         bad++;
         $display("FAIL arming_early got=%b required=0", bus1.trojan_active);
      end
      send1(8'hFF, 8'hFF, 3'b000, 8'hFF, 1'b1, 1'b0);
      total++;
      if (bus1.trojan_active !== 1'b1) begin
         bad++;
         $display("FAIL arming_rise got=%b required=1", bus1.trojan_active);
      end
      drain("arming");
      total++;
      if (bus1.trojan_active !== 1'b1) begin
         bad++;
         $display("FAIL arming_hold got=%b required=1", bus1.trojan_active);
      end
   endtask

   task automatic test_gap();
      do_reset();
      send1(8'hFF, 8'hFF, 3'b000, 8'hFE, 1'b1, 1'b0);
      send1(8'hFF, 8'hFF, 3'b000, 8'hFE, 1'b1, 1'b0);
      idle(5);
      total++;
      if (bus1.trojan_active !== 1'b0) begin
         bad++;
         $display("FAIL gap_idle got=%b required=0", bus1.trojan_active);
      end
      send1(8'hFF, 8'hFF, 3'b000, 8'hFE, 1'b1, 1'b0);
      send1(8'hFF, 8'hFF, 3'b000, 8'hFF, 1'b1, 1'b0);
      drain("gap");
      total++;
      if (bus1.trojan_active !== 1'b1) begin
         bad++;
         $display("FAIL gap_active got=%b required=1", bus1.trojan_active);
      end
   endtask

   task automatic test_disarm();
      send1(8'hFF, 8'hFF, 3'b010, 8'hFF, 1'b0, 1'b0);
      send1(8'hFF, 8'hFF, 3'b000, 8'hFE, 1'b1, 1'b0);
      total++;
      if (bus1.trojan_active !== 1'b0) begin
         bad++;
         $display("FAIL disarm_drop got=%b required=0", bus1.trojan_active);
      end
      drain("disarm");
   endtask

   task automatic test_reset_mid();
      logic [13:0] got;
      do_reset();
      send1(8'hFF, 8'hFF, 3'b000, 8'hFE, 1'b1, 1'b0);
      send1(8'hFF, 8'hFF, 3'b000, 8'hFE, 1'b1, 1'b0);
      send1(8'hFF, 8'hFF, 3'b000, 8'hFE, 1'b1, 1'b0);
      idle(1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      got = {bus1.out_valid, bus1.result, bus1.carry, bus1.zero, bus1.negative,
             bus1.overflow, bus1.trojan_active};
      total++;
      if (got !== 14'h0) begin
         bad++;
         $display("FAIL reset_mid_async got=%h required=0000", got);
      end
      @(negedge clk);
      rst = 1'b0;
      send1(8'hFF, 8'hFF, 3'b000, 8'hFE, 1'b1, 1'b0);
      drain("reset_mid");
   endtask

   task automatic test_trojan_off();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         send0(8'hFF, 8'hFF, 3'b000, 8'hFE, 1'b1, 1'b0);
         total++;
         if (bus0.trojan_active !== 1'b0) begin
            bad++;
            $display("FAIL off_active iter=%0d got=%b required=0", i, bus0.trojan_active);
         end
      end
      drain("trojan_off");
   endtask

   initial begin
      rst           = 1'b1;
      bus1.in_valid = 1'b0;
      bus1.A        = 8'h00;
      bus1.B        = 8'h00;
      bus1.op       = 3'b000;
      bus0.in_valid = 1'b0;
      bus0.A        = 8'h00;
      bus0.B        = 8'h00;
      bus0.op       = 3'b000;
      test_reset();
      test_arith();
      test_arming();
      test_gap();
      test_disarm();
      test_reset_mid();
      test_trojan_off();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
